// File: rtl/delay_line_ctrl_pkg.sv
// rtl/delay_line_ctrl_pkg.sv - shared constants and helpers for the delay-line controller
package delay_line_ctrl_pkg;

  localparam int FIFO_ENTRIES = 3;
  localparam int FIFO_CNT_W   = 2;
  localparam int OCC_W        = FIFO_CNT_W + 1;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/delay_line_ctrl_small_fifo.sv
// rtl/delay_line_ctrl_small_fifo.sv - three-entry output buffer with occupancy count
module delay_line_ctrl_small_fifo
  import delay_line_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      head_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  localparam logic [FIFO_CNT_W-1:0] LAST = FIFO_CNT_W'(FIFO_ENTRIES - 1);
  localparam logic [FIFO_CNT_W-1:0] FULL = FIFO_CNT_W'(FIFO_ENTRIES);

  logic [WIDTH-1:0]      mem_q [FIFO_ENTRIES];
  logic [FIFO_CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  do_push, do_pop;

  // A push into a full buffer only lands when a pop frees a slot in the same cycle
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + FIFO_CNT_W'(1);
    if (do_push)
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + FIFO_CNT_W'(1);
    if (do_push && !do_pop)
      count_d = count_q + FIFO_CNT_W'(1);
    else if (!do_push && do_pop)
      count_d = count_q - FIFO_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_ENTRIES; i++)
        mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push)
        mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/delay_line_ctrl.sv
// rtl/delay_line_ctrl.sv - circular-buffer sample delay line in front of a 1-cycle-read dual-port RAM
module delay_line_ctrl
  import delay_line_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [ADDR_WIDTH-1:0] delay,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [WIDTH-1:0]      ram_wr_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [WIDTH-1:0]      ram_rd_data
);

  if (!is_pow2(DEPTH)) begin : g_depth_check
    $error("delay_line_ctrl: DEPTH must be a power of two");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
  logic [ADDR_WIDTH-1:0] delay_q, delay_d;
  logic                  pend_q, pend_zero_q, pend_bypass_q;
  logic [WIDTH-1:0]      pend_data_q;

  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [OCC_W-1:0]      occupancy;
  logic [WIDTH-1:0]      fifo_head, fifo_push_data;
  logic                  accept, zero, bypass, fifo_pop;

  // Occupancy counts the in-flight pend slot so s_ready never depends on m_ready
  assign occupancy = {1'b0, fifo_count} + OCC_W'(pend_q);
  assign s_ready   = occupancy < OCC_W'(FIFO_ENTRIES);

  assign accept = s_valid && s_ready && n_reset;
  assign zero   = fill_cnt_q < delay_q;
  assign bypass = (delay_q == '0);

  assign ram_wr_en   = accept;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_wr_data = accept ? s_data : '0;
  assign ram_rd_en   = accept && !zero && !bypass;
  assign ram_rd_addr = wr_ptr_q - delay_q;

  always_comb begin
    wr_ptr_d   = accept ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    delay_d    = delay_q;
    fill_cnt_d = fill_cnt_q;
    // A new delay restarts the zero-fill; a sample accepted this cycle still used the old one
    if (delay != delay_q) begin
      delay_d    = delay;
      fill_cnt_d = '0;
    end else if (accept && zero) begin
      fill_cnt_d = fill_cnt_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q      <= '0;
      fill_cnt_q    <= '0;
      delay_q       <= '0;
      pend_q        <= 1'b0;
      pend_zero_q   <= 1'b0;
      pend_bypass_q <= 1'b0;
      pend_data_q   <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      fill_cnt_q    <= fill_cnt_d;
      delay_q       <= delay_d;
      pend_q        <= accept;
      pend_zero_q   <= zero;
      pend_bypass_q <= bypass;
      if (accept)
        pend_data_q <= s_data;
    end
  end

  assign fifo_push_data = pend_zero_q   ? '0          :
                          pend_bypass_q ? pend_data_q : ram_rd_data;

  assign m_valid  = (fifo_count != '0);
  assign m_data   = fifo_head;
  assign fifo_pop = m_valid && m_ready;

  delay_line_ctrl_small_fifo #(
    .WIDTH (WIDTH)
  ) u_out_fifo (
    .clk         (clk),
    .n_reset     (n_reset),
    .push_i      (pend_q),
    .push_data_i (fifo_push_data),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_delay_line_ctrl.sv
// tb/tb_delay_line_ctrl.sv - self-checking bench for delay_line_ctrl with a RAM model and scoreboard
module tb_delay_line_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic            clk = 1'b0;
  logic            n_reset = 1'b0;
  logic [AW-1:0]   delay = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [WIDTH-1:0] s_data = '0;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic [WIDTH-1:0] m_data;
  logic            ram_wr_en, ram_rd_en;
  logic [AW-1:0]   ram_wr_addr, ram_rd_addr;
  logic [WIDTH-1:0] ram_wr_data;
  logic [WIDTH-1:0] ram_rd_data = '0;
  logic [WIDTH-1:0] ram [DEPTH];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
  end

  delay_line_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .n_reset(n_reset), .delay(delay),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  typedef struct { logic [7:0] data; int t; } ent_t;
  typedef struct { logic sv; logic [7:0] sd; logic ev; logic [7:0] ed; } vec_t;

  ent_t       sb[$];
  logic [7:0] hist[$];
  logic [7:0] got[$];
  int         exq[$];
  int         cnt_since = 0, mdl_d = 0, now = 0;
  int         n_cmp = 0, n_err = 0, rd_en_cnt = 0, total_acc = 0;
  logic       smp_mv, last_acc;
  logic [7:0] smp_md;
  vec_t       vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: actual %0d required %0d", name, $time, act, exp);
    end
  endtask

  // One clock cycle: check outputs at the negedge, then advance the reference at the posedge
  task automatic step();
    bit exp_sr, exp_mv, acc, pop, exp_rd;
    logic [7:0] exp_data;
    exp_data = '0;
    @(negedge clk);
    exp_sr = (sb.size() < 3);
    exp_mv = (sb.size() > 0) && (sb[0].t + 2 <= now);
    smp_mv = m_valid;
    smp_md = m_data;
    chk("s_ready", s_ready, exp_sr);
    chk("m_valid", m_valid, exp_mv);
    if (exp_mv) chk("m_data", m_data, sb[0].data);
    acc    = s_valid && exp_sr;
    pop    = exp_mv && m_ready;
    exp_rd = acc && (mdl_d != 0) && (cnt_since >= mdl_d);
    chk("ram_wr_en", ram_wr_en, acc);
    chk("ram_rd_en", ram_rd_en, exp_rd);
    if (ram_rd_en) rd_en_cnt++;
    if (m_valid && m_ready) got.push_back(m_data);
    if (acc) begin
      if (mdl_d == 0)              exp_data = s_data;
      else if (cnt_since < mdl_d)  exp_data = '0;
      else                         exp_data = hist[hist.size() - mdl_d];
      cnt_since++;
      total_acc++;
      hist.push_back(s_data);
    end
    last_acc = acc;
    @(posedge clk);
    if (pop) void'(sb.pop_front());
    if (acc) sb.push_back('{exp_data, now});
    if (int'(delay) != mdl_d) begin
      mdl_d     = int'(delay);
      cnt_since = 0;
    end
    now++;
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (n) step();
  endtask

  task automatic feed(input int first, input int n);
    m_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      int tries;
      tries = 0;
      s_valid = 1'b1;
      s_data  = 8'(first + i);
      do begin
        step();
        tries++;
      end while (!last_acc && tries < 20);
      if (!last_acc) chk("feed_timeout", 0, 1);
    end
    s_valid = 1'b0;
  endtask

  task automatic chk_list(input string name);
    chk({name, "_len"}, got.size(), exq.size());
    for (int i = 0; i < exq.size() && i < got.size(); i++)
      chk(name, got[i], exq[i]);
  endtask

  initial begin
    vt[0]  = '{1, 1, 0, 0};  vt[1]  = '{1, 2, 0, 0};
    vt[2]  = '{1, 3, 1, 0};  vt[3]  = '{1, 4, 1, 0};
    vt[4]  = '{1, 5, 1, 0};  vt[5]  = '{1, 6, 1, 0};
    vt[6]  = '{1, 7, 1, 1};  vt[7]  = '{1, 8, 1, 2};
    vt[8]  = '{1, 9, 1, 3};  vt[9]  = '{1, 10, 1, 4};
    vt[10] = '{1, 11, 1, 5}; vt[11] = '{1, 12, 1, 6};
    vt[12] = '{0, 0, 1, 7};  vt[13] = '{0, 0, 1, 8};
    vt[14] = '{0, 0, 0, 0};  vt[15] = '{0, 0, 0, 0};
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'hEE;

    // reset state, with a sample offered while reset is held
    s_valid = 1'b1;
    s_data  = 8'h5A;
    #3;
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_s_ready", s_ready, 1);
    chk("reset_wr_en", ram_wr_en, 0);
    chk("reset_rd_en", ram_rd_en, 0);
    @(posedge clk); #1;
    n_reset = 1'b1;
    s_valid = 1'b0;

    // D=4, continuous 1..12: table of per-cycle expectations
    delay = 3'd4;
    idle(2);
    for (int i = 0; i < 16; i++) begin
      s_valid = vt[i].sv;
      s_data  = vt[i].sd;
      m_ready = 1'b1;
      step();
      chk("tbl_m_valid", smp_mv, vt[i].ev);
      if (vt[i].ev) chk("tbl_m_data", smp_md, vt[i].ed);
    end

    // D=0 passthrough, RAM read never used
    delay = 3'd0;
    idle(2);
    got.delete();
    begin
      int rd0;
      rd0 = rd_en_cnt;
      feed(1, 8);
      idle(4);
      chk("d0_rd_en_count", rd_en_cnt - rd0, 0);
    end
    exq = '{1, 2, 3, 4, 5, 6, 7, 8};
    chk_list("d0_out");

    // D=3 with random valid/ready
    delay = 3'd3;
    idle(2);
    got.delete();
    begin
      int acc0;
      acc0 = total_acc;
      for (int i = 0; i < 300; i++) begin
        s_valid = ($urandom % 4) != 0;
        s_data  = 8'($urandom);
        m_ready = 1'($urandom);
        step();
      end
      idle(8);
      chk("d3_count", got.size(), total_acc - acc0);
    end

    // D=7 on an 8-deep RAM: pointer wraps
    delay = 3'd7;
    idle(2);
    got.delete();
    feed(1, 20);
    idle(5);
    exq = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
    chk_list("d7_out");

    // D=2 then switch to D=4 after sample 6
    delay = 3'd2;
    idle(2);
    got.delete();
    feed(1, 6);
    delay = 3'd4;
    idle(1);
    feed(7, 8);
    idle(5);
    exq = '{0, 0, 1, 2, 3, 4, 0, 0, 0, 0, 7, 8, 9, 10};
    chk_list("dchg_out");

    // delay change in the same cycle as an accept
    delay = 3'd1;
    idle(2);
    s_valid = 1'b1;
    s_data  = 8'd99;
    delay   = 3'd3;
    step();
    s_valid = 1'b0;
    feed(100, 6);
    idle(5);

    // fill the output path with m_ready low, then reset mid-cycle
    delay = 3'd2;
    idle(3);
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 8'(200 + i);
      step();
    end
    #2 n_reset = 1'b0;
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_s_ready", s_ready, 1);
    chk("mid_rst_wr_en", ram_wr_en, 0);
    sb.delete();
    hist.delete();
    cnt_since = 0;
    mdl_d     = 0;
    s_valid   = 1'b0;
    m_ready   = 1'b1;
    @(posedge clk); #1;
    n_reset = 1'b1;
    idle(2);
    got.delete();
    feed(50, 3);
    idle(4);
    exq = '{0, 0, 50};
    chk_list("rst_restart_out");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
